// File: rtl/reset_sequencer.sv
// Staged reset-release controller.
// After arstn release all stage resets stay asserted for HOLD_CYCLES edges.
// The stages are then released one at a time, index 0 first, STAGE_DELAY
// edges apart. The sequencer then waits for init_done, or gives up after
// TIMEOUT_CYCLES edges, and raises sys_ready.
// A software request re-runs the whole sequence from HOLD. timeout_err is
// sticky until arstn.
module reset_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGE_DELAY    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  sw_rst_req,
    input  logic                  init_done,
    output logic [NUM_STAGES-1:0] stage_rstn,
    output logic                  sys_ready,
    output logic                  timeout_err,
    output logic [1:0]            seq_state
);

    localparam int MAX_HS  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int MAX_ALL = (MAX_HS > TIMEOUT_CYCLES) ? MAX_HS : TIMEOUT_CYCLES;
    localparam int MAX_PAR = (MAX_ALL > NUM_STAGES) ? MAX_ALL : NUM_STAGES;
    localparam int CNT_W   = $clog2(MAX_PAR + 1);
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        stage_idx_q, stage_idx_d;
    logic [NUM_STAGES-1:0]   stage_rstn_q, stage_rstn_d;
    logic                    sys_ready_q, sys_ready_d;
    logic                    timeout_err_q, timeout_err_d;

    // State and output registers; arstn forces every stage back into reset.
    // NOTE: sequential state uses non-blocking assignments so that all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            stage_idx_q   <= '0;
            stage_rstn_q  <= '0;
            sys_ready_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage_idx_q   <= stage_idx_d;
            stage_rstn_q  <= stage_rstn_d;
            sys_ready_q   <= sys_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic: software request first, then per-state sequencing.
    // NOTE: every signal gets a hold-value default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stage_idx_d   = stage_idx_q;
        stage_rstn_d  = stage_rstn_q;
        sys_ready_d   = sys_ready_q;
        timeout_err_d = timeout_err_q;

        if (sw_rst_req) begin
            // timeout_err deliberately survives a software restart.
            state_d      = ST_HOLD;
            cnt_d        = '0;
            stage_idx_d  = '0;
            stage_rstn_d = '0;
            sys_ready_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        stage_rstn_d[0] = 1'b1;
                        cnt_d           = '0;
                        if (NUM_STAGES == 1) begin
                            state_d = ST_WAIT_DONE;
                        end else begin
                            state_d     = ST_RELEASE;
                            stage_idx_d = IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                        stage_rstn_d[stage_idx_q] = 1'b1;
                        cnt_d                     = '0;
                        if (stage_idx_q == IDX_W'(NUM_STAGES - 1)) begin
                            state_d = ST_WAIT_DONE;
                        end else begin
                            stage_idx_d = stage_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (init_done) begin
                        sys_ready_d = 1'b1;
                        state_d     = ST_RUN;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Give up on the handshake but let the system run.
                        timeout_err_d = 1'b1;
                        sys_ready_d   = 1'b1;
                        state_d       = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Outputs hold; init_done is ignored here.
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    assign stage_rstn  = stage_rstn_q;
    assign sys_ready   = sys_ready_q;
    assign timeout_err = timeout_err_q;
    assign seq_state   = state_q;

endmodule
